// File: rtl/ram_pkg.sv
// Shared widths and FSM state encoding for the RAM controller slice.
package ram_pkg;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETUP    = 2'd1,
      ACCESS   = 2'd2,
      FILL_CHK = 2'd3
   } state_t;

endpackage

// File: rtl/ram_ctrl_if.sv
// Host-side request/fill/response bundle between a bus master and ram_ctrl.
interface ram_ctrl_if #(
   parameter int ADDR_W = ram_pkg::ADDR_W,
   parameter int DATA_W = ram_pkg::DATA_W
);

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              fill_start;
   logic [ADDR_W-1:0] fill_base;
   logic [ADDR_W-1:0] fill_len;
   logic [DATA_W-1:0] fill_value;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              fill_done;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      output fill_start, fill_base, fill_len, fill_value,
      input  req_ready, rsp_valid, rsp_rdata, fill_done
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      input  fill_start, fill_base, fill_len, fill_value,
      output req_ready, rsp_valid, rsp_rdata, fill_done
   );

endinterface

// File: rtl/ram_addr_gen.sv
// Block-fill address and remaining-word counter; address wraps modulo 2^ADDR_W.
module ram_addr_gen #(
   parameter int ADDR_W = ram_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              inc,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] len,
   output logic [ADDR_W-1:0] next_addr,
   output logic              last
);

   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] remaining;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr      <= '0;
         remaining <= '0;
      end else if (load) begin
         addr      <= base;
         remaining <= len;
      end else if (inc) begin
         addr      <= next_addr;
         remaining <= remaining - ADDR_W'(1);
      end
   end

   assign next_addr = addr + ADDR_W'(1);
   assign last      = (remaining == ADDR_W'(1));

endmodule

// File: rtl/ram_ctrl.sv
// Single-port async SRAM controller: single read/write accesses and block fills.
module ram_ctrl
   import ram_pkg::*;
#(
   parameter int ADDR_W = ram_pkg::ADDR_W,
   parameter int DATA_W = ram_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   ram_ctrl_if.slave         host,
   output logic [ADDR_W-1:0] address_ram,
   output logic              cs,
   output logic              we,
   inout  wire  [DATA_W-1:0] data
);

   state_t            state;
   logic              is_fill;
   logic              is_write;
   logic [DATA_W-1:0] wdata_q;
   logic              accept_fill;
   logic              accept_req;
   logic              ag_inc;
   logic              ag_last;
   logic [ADDR_W-1:0] ag_next;

   // A simultaneous fill_start wins; the request stays pending in IDLE.
   assign accept_fill = (state == IDLE) && host.req_ready && host.fill_start;
   assign accept_req  = (state == IDLE) && host.req_ready && host.req_valid && !host.fill_start;
   assign ag_inc      = (state == ACCESS) && is_fill;

   ram_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept_fill),
      .inc       (ag_inc),
      .base      (host.fill_base),
      .len       (host.fill_len),
      .next_addr (ag_next),
      .last      (ag_last)
   );

   always_ff @(posedge clk) begin
      if (accept_fill)
         wdata_q <= host.fill_value;
      else if (accept_req)
         wdata_q <= host.req_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         is_fill        <= 1'b0;
         is_write       <= 1'b0;
         host.req_ready <= 1'b0;
         host.rsp_valid <= 1'b0;
         host.rsp_rdata <= '0;
         host.fill_done <= 1'b0;
         address_ram    <= '0;
         cs             <= 1'b0;
         we             <= 1'b0;
      end else begin
         host.rsp_valid <= 1'b0;
         host.fill_done <= 1'b0;
         case (state)
            IDLE: begin
               host.req_ready <= 1'b1;
               if (accept_fill) begin
                  is_fill        <= 1'b1;
                  is_write       <= 1'b1;
                  host.req_ready <= 1'b0;
                  if (host.fill_len == '0) begin
                     state <= FILL_CHK;
                  end else begin
                     state       <= SETUP;
                     cs          <= 1'b1;
                     address_ram <= host.fill_base;
                  end
               end else if (accept_req) begin
                  is_fill        <= 1'b0;
                  is_write       <= host.req_we;
                  host.req_ready <= 1'b0;
                  state          <= SETUP;
                  cs             <= 1'b1;
                  address_ram    <= host.req_addr;
               end
            end
            SETUP: begin
               state <= ACCESS;
               we    <= is_write;
            end
            ACCESS: begin
               we <= 1'b0;
               if (is_fill && !ag_last) begin
                  // Next fill word goes straight back to SETUP, keeping cs asserted.
                  state       <= SETUP;
                  address_ram <= ag_next;
               end else if (is_fill) begin
                  state <= FILL_CHK;
                  cs    <= 1'b0;
               end else begin
                  state          <= IDLE;
                  cs             <= 1'b0;
                  host.req_ready <= 1'b1;
                  host.rsp_valid <= 1'b1;
                  if (!is_write)
                     host.rsp_rdata <= data;
               end
            end
            FILL_CHK: begin
               state          <= IDLE;
               host.req_ready <= 1'b1;
               host.fill_done <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign data = we ? wdata_q : 'z;

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl with a behavioural RAM on the shared data bus.
module tb_ram_ctrl;
   import ram_pkg::*;

   localparam int AW = ADDR_W;
   localparam int DW = DATA_W;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] address_ram;
   logic          cs;
   logic          we;
   wire  [DW-1:0] data;

   ram_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   ram_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .host        (bus.slave),
      .address_ram (address_ram),
      .cs          (cs),
      .we          (we),
      .data        (data)
   );

   always #5 clk = ~clk;

   // RAM model drives the bus on any selected non-write cycle; pull-ups expose an undriven bus as all ones.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   assign data = (cs && !we) ? mem[address_ram] : 'z;
   for (genvar i = 0; i < DW; i++) begin : g_pu
      pullup (data[i]);
   end

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   typedef struct {
      bit            fill;
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [AW-1:0] len;
      logic [DW-1:0] exp_rd;
      int            exp_lat;
   } vec_t;

   int   errors = 0;
   int   checks = 0;
   bit   mon_en = 1'b0;
   wr_t  wlog[$];
   vec_t vecs[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic bus_monitor();
      logic          prev_cs = 1'b0;
      logic          prev_we = 1'b0;
      logic [AW-1:0] prev_addr = '0;
      forever begin
         @(negedge clk);
         if (rst_n && mon_en) begin
            if (!cs) begin
               check("bus_hiz_when_idle", {we, data}, {1'b0, {DW{1'b1}}});
            end else if (!we) begin
               check("bus_read_only_ram", data, mem[address_ram]);
            end else begin
               wlog.push_back('{address_ram, data});
               mem[address_ram] = data;
            end
            if (prev_cs && !prev_we && cs)
               check("addr_stable_setup_access", address_ram, prev_addr);
         end
         prev_cs   = cs;
         prev_we   = we;
         prev_addr = address_ram;
      end
   endtask

   task automatic wait_ready(input string name);
      int waited = 0;
      @(negedge clk);
      while (!bus.req_ready && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      check({name, "_ready"}, bus.req_ready, 1);
      wlog.delete();
   endtask

   task automatic do_access(input int idx, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
      int            seen = 0;
      int            lat = 0;
      logic [DW-1:0] rd = '0;
      wait_ready($sformatf("v%0d", idx));
      bus.req_valid = 1'b1;
      bus.req_we    = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (bus.rsp_valid) begin
            seen++;
            lat = k;
            rd  = bus.rsp_rdata;
         end
      end
      check($sformatf("v%0d_rsp_latency", idx), lat, 3);
      check($sformatf("v%0d_rsp_pulses", idx), seen, 1);
      check($sformatf("v%0d_rsp_rdata", idx), rd, exp_rd);
      if (w) begin
         check($sformatf("v%0d_write_count", idx), wlog.size(), 1);
         if (wlog.size() == 1)
            check($sformatf("v%0d_write_word", idx), {wlog[0].a, wlog[0].d}, {a, d});
      end else begin
         check($sformatf("v%0d_no_write_on_read", idx), wlog.size(), 0);
      end
   endtask

   task automatic do_fill(input int idx, input logic [AW-1:0] base, input logic [AW-1:0] len,
                          input logic [DW-1:0] val, input int exp_lat);
      int done_at = 0;
      int n_done = 0;
      int cs_cnt = 0;
      wait_ready($sformatf("v%0d", idx));
      bus.fill_start = 1'b1;
      bus.fill_base  = base;
      bus.fill_len   = len;
      bus.fill_value = val;
      @(posedge clk);
      #1 bus.fill_start = 1'b0;
      for (int k = 1; k <= exp_lat + 6; k++) begin
         @(negedge clk);
         if (cs) cs_cnt++;
         if (bus.fill_done) begin
            n_done++;
            done_at = k;
         end
      end
      check($sformatf("v%0d_fill_done_latency", idx), done_at, exp_lat);
      check($sformatf("v%0d_fill_done_pulses", idx), n_done, 1);
      check($sformatf("v%0d_fill_cs_cycles", idx), cs_cnt, 2 * int'(len));
      check($sformatf("v%0d_fill_write_count", idx), wlog.size(), int'(len));
      for (int i = 0; i < wlog.size() && i < int'(len); i++)
         check($sformatf("v%0d_fill_word%0d", idx, i), {wlog[i].a, wlog[i].d},
               {AW'(base + AW'(i)), val});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      int            fd_at;
      int            rv_at;
      int            pulses;
      bit            dropped;
      logic [DW-1:0] rd;
      logic [11:0]   mask;

      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.fill_start = 1'b0;
      bus.fill_base  = '0;
      bus.fill_len   = '0;
      bus.fill_value = '0;

      vecs[0]  = '{0, 1'b1, 12'h000, 4'b0011, 12'd0, 4'b0000, 0};
      vecs[1]  = '{0, 1'b1, 12'h001, 4'b1110, 12'd0, 4'b0000, 0};
      vecs[2]  = '{0, 1'b1, 12'h002, 4'b0101, 12'd0, 4'b0000, 0};
      vecs[3]  = '{0, 1'b0, 12'h000, 4'b0000, 12'd0, 4'b0011, 0};
      vecs[4]  = '{0, 1'b0, 12'h001, 4'b0000, 12'd0, 4'b1110, 0};
      vecs[5]  = '{0, 1'b0, 12'h002, 4'b0000, 12'd0, 4'b0101, 0};
      vecs[6]  = '{1, 1'b1, 12'hFFE, 4'b1010, 12'd4, 4'b0000, 10};
      vecs[7]  = '{0, 1'b0, 12'h000, 4'b0000, 12'd0, 4'b1010, 0};
      vecs[8]  = '{0, 1'b0, 12'hFFF, 4'b0000, 12'd0, 4'b1010, 0};
      vecs[9]  = '{0, 1'b0, 12'h002, 4'b0000, 12'd0, 4'b0101, 0};
      vecs[10] = '{1, 1'b1, 12'h123, 4'b0111, 12'd0, 4'b0000, 2};
      vecs[11] = '{0, 1'b1, 12'hABC, 4'b1001, 12'd0, 4'b0101, 0};
      vecs[12] = '{0, 1'b0, 12'hABC, 4'b0000, 12'd0, 4'b1001, 0};
      vecs[13] = '{0, 1'b1, 12'h000, 4'b0110, 12'd0, 4'b1001, 0};
      vecs[14] = '{0, 1'b0, 12'h000, 4'b0000, 12'd0, 4'b0110, 0};

      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      check("reset_req_ready", bus.req_ready, 0);
      check("reset_cs_we", {cs, we}, 2'b00);
      check("reset_address", address_ram, 0);
      check("reset_pulses", {bus.rsp_valid, bus.fill_done}, 2'b00);
      check("reset_rdata", bus.rsp_rdata, 0);
      check("reset_data_hiz", data, {DW{1'b1}});
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_release", bus.req_ready, 1);

      mon_en = 1'b1;
      fork
         bus_monitor();
      join_none

      foreach (vecs[i]) begin
         if (vecs[i].fill)
            do_fill(i, vecs[i].a, vecs[i].len, vecs[i].d, vecs[i].exp_lat);
         else
            do_access(i, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_rd);
      end

      // Fill and read requested together: fill first, read accepted while fill_done is high.
      wait_ready("collide");
      bus.fill_start = 1'b1;
      bus.fill_base  = 12'h010;
      bus.fill_len   = 12'd1;
      bus.fill_value = 4'b1100;
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b0;
      bus.req_addr   = 12'h010;
      @(posedge clk);
      #1 bus.fill_start = 1'b0;
      fd_at = 0; rv_at = 0; rd = '0; dropped = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (bus.fill_done) fd_at = k;
         if (bus.rsp_valid) begin
            rv_at = k;
            rd    = bus.rsp_rdata;
         end
         if (bus.fill_done && !dropped) begin
            @(posedge clk);
            #1 bus.req_valid = 1'b0;
            dropped = 1'b1;
         end
      end
      check("collide_fill_done_cycle", fd_at, 4);
      check("collide_rsp_cycle", rv_at, 7);
      check("collide_rdata", rd, 4'b1100);

      // Held read request: one completion every third cycle.
      wait_ready("throughput");
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = 12'hABC;
      @(posedge clk);
      #1;
      mask = '0; pulses = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (bus.rsp_valid) begin
            mask[k-1] = 1'b1;
            pulses++;
            check($sformatf("throughput_rdata_%0d", pulses), bus.rsp_rdata, 4'b1001);
         end
         if (k == 7) bus.req_valid = 1'b0;
      end
      check("throughput_pulse_cycles", mask, 12'b0001_0010_0100);

      // Reset asserted in the middle of a write ACCESS.
      wait_ready("rst_mid");
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 12'h055;
      bus.req_wdata = 4'b0101;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(posedge clk);
      #2;
      check("rst_mid_access_drive", {cs, we, data}, {2'b11, 4'b0101});
      rst_n = 1'b0;
      #1;
      check("rst_mid_cs_we", {cs, we}, 2'b00);
      check("rst_mid_data_hiz", data, {DW{1'b1}});
      check("rst_mid_ready_addr", {bus.req_ready, address_ram}, 0);
      check("rst_mid_rdata", bus.rsp_rdata, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) check("rst_mid_ready_after", bus.req_ready, 1);
         if (bus.rsp_valid || bus.fill_done) pulses++;
      end
      check("rst_mid_no_pulse", pulses, 0);
      do_access(100, 1'b0, 12'h055, 4'b0000, 4'b0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
